rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4-to-1 multiplexer datapath among four requesters.

---
 rtl/rr_mux_arbiter_if.sv | 18 +
 rtl/rr_mux_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Bus between four requesters and the round-robin mux arbiter: requests, data lanes,
// registered grant/select/busy, and the forwarded data word.
interface rr_mux_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic [DATA_W-1:0] y;

  modport master (output req, d0, d1, d2, d3, input gnt, sel, busy, y);
  modport slave  (input req, d0, d1, d2, d3, output gnt, sel, busy, y);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a 4:1 data mux; one idle bubble between grants.
// Optional macro ARB_TIMEOUT_EN force-releases an owner after HOLD_MAX cycles when others wait.
module rr_mux_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  rr_mux_arbiter_if.slave     bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_mux_arbiter: HOLD_MAX must be in 2..255");
  end

  state_e      state_q, state_d;
  logic [3:0]  gnt_q,   gnt_d;
  logic [1:0]  sel_q,   sel_d;
  logic        busy_q,  busy_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic        release_now;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);
  logic [7:0]  hold_cnt_q, hold_cnt_d;
`endif

  // First requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    win   = rr_ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      GRANT: begin
        release_now = !bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
        // Saturated counters still qualify, so a late competitor cannot be locked out.
        if (hold_cnt_q >= HOLD_LAST && (bus.req & ~gnt_q) != 4'b0000)
          release_now = 1'b1;
`endif
        if (release_now) begin
          gnt_d    = 4'b0000;
          busy_d   = 1'b0;
          rr_ptr_d = sel_q + 2'd1;
          state_d  = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q < HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_cnt_q <= 8'd0;
    else          hold_cnt_q <= hold_cnt_d;
  end
`endif

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

  always_comb begin
    bus.y = '0;
    if (busy_q) begin
      unique case (sel_q)
        2'd0: bus.y = bus.d0;
        2'd1: bus.y = bus.d1;
        2'd2: bus.y = bus.d2;
        2'd3: bus.y = bus.d3;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic compared against a grant-level reference model.
module tb_rr_mux_arbiter;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned HOLD_MAX = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0]        req_v = 4'b0000;
  logic [DATA_W-1:0] d_v [4];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the mux, who is next in line, how long the grant has lasted.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_held  = 0;

  rr_mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

  assign bus.req = req_v;
  assign bus.d0  = d_v[0];
  assign bus.d1  = d_v[1];
  assign bus.d2  = d_v[2];
  assign bus.d3  = d_v[3];

  rr_mux_arbiter #(.DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int first_from_ptr(input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_held  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    bit drop;
    bit expire;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = first_from_ptr(r);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else begin
      drop   = !r[m_owner];
      expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
      expire = (m_held >= HOLD_MAX) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`endif
      if (drop || expire) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0]        e_gnt;
    logic              e_busy;
    logic [DATA_W-1:0] e_y;
    e_busy = (m_owner >= 0);
    e_gnt  = e_busy ? 4'(1 << m_owner) : 4'b0000;
    e_y    = e_busy ? d_v[m_last] : '0;
    check({name, ".gnt"},  32'(bus.gnt),  32'(e_gnt));
    check({name, ".sel"},  32'(bus.sel),  32'(m_last));
    check({name, ".busy"}, 32'(bus.busy), 32'(e_busy));
    check({name, ".y"},    32'(bus.y),    32'(e_y));
  endtask

  // One clock edge with the currently driven inputs; outputs sampled 1 ns later.
  task automatic tick();
    logic [3:0] r;
    r = req_v;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    model_reset();
    #1;
    check({name, ".rst_gnt"},  32'(bus.gnt),  32'h0);
    check({name, ".rst_sel"},  32'(bus.sel),  32'h0);
    check({name, ".rst_busy"}, 32'(bus.busy), 32'h0);
    check({name, ".rst_y"},    32'(bus.y),    32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl [14];
  localparam logic [3:0] RR_ORDER [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int cnt;
    logic [3:0] m;

    d_v[0] = 8'h11; d_v[1] = 8'h22; d_v[2] = 8'hA5; d_v[3] = 8'h33;

    //             req      gnt      sel  busy  y
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[5]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'hA5};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 8'h00};
    tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 8'h33};
    tbl[8]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, 8'h00};
    tbl[9]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 8'h11};
    tbl[10] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 8'h11};
    tbl[11] = '{4'b0010, 4'b0000, 2'd0, 1'b0, 8'h00};
    tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 8'h22};
    tbl[13] = '{4'b0000, 4'b0000, 2'd1, 1'b0, 8'h00};

    // Reset with every requester active, then first grant after release.
    req_v = 4'b1111;
    do_reset("reset");
    tick();
    check("reset.first_gnt", 32'(bus.gnt), 32'h1);
    check_model("reset.model");

    // Directed table: single requester, pointer wrap, ignored non-owner, drop+request edge.
    req_v = 4'b0000;
    do_reset("table");
    for (int i = 0; i < 14; i++) begin
      req_v = tbl[i].req;
      tick();
      check($sformatf("tbl%0d.gnt", i),  32'(bus.gnt),  32'(tbl[i].gnt));
      check($sformatf("tbl%0d.sel", i),  32'(bus.sel),  32'(tbl[i].sel));
      check($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d.y", i),    32'(bus.y),    32'(tbl[i].y));
    end

    // Round-robin with all four requesting; each owner drops for one cycle after 3 grants.
    req_v = 4'b0000;
    do_reset("rr");
    req_v = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("rr%0d.gnt", g), 32'(bus.gnt), 32'(RR_ORDER[g]));
      tick();
      tick();
      check_model($sformatf("rr%0d.hold", g));
      req_v = 4'b1111 & ~RR_ORDER[g];
      tick();
      check($sformatf("rr%0d.idle", g), 32'(bus.gnt), 32'h0);
      req_v = 4'b1111;
    end

    // Requester 0 holds forever; requester 1 joins on the second grant cycle.
    req_v = 4'b0000;
    do_reset("tmo");
    req_v = 4'b0001;
    tick();
    req_v = 4'b0011;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_model("tmo.model");
      if (bus.gnt != 4'b0001) break;
      cnt++;
    end
`ifdef ARB_TIMEOUT_EN
    check("tmo.len", 32'(cnt), 32'(HOLD_MAX));
    check("tmo.bubble", 32'(bus.gnt), 32'h0);
    tick();
    check("tmo.next", 32'(bus.gnt), 32'h2);
`else
    check("tmo.never_drops", 32'(cnt), 32'd41);
`endif

    // Reset pulse while requester 1 owns the mux.
    req_v = 4'b0000;
    do_reset("mid");
    req_v = 4'b0010;
    tick();
    check("mid.owner1", 32'(bus.gnt), 32'h2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid.async_gnt",  32'(bus.gnt),  32'h0);
    check("mid.async_busy", 32'(bus.busy), 32'h0);
    req_v = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mid.regrant", 32'(bus.gnt), 32'h2);

    // Randomized traffic: sticky requests toggled occasionally, fresh lane data every cycle.
    req_v = 4'b0000;
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      m = 4'($urandom & $urandom);
      req_v = req_v ^ m;
      for (int l = 0; l < 4; l++) d_v[l] = 8'($urandom);
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
